// File: rtl/gigatron_video_capture.sv
// gigatron_video_capture
//
// Captures the Gigatron CPU's OUT port into a 160x120 framebuffer. OUT[7] is
// VSYNC and OUT[6] is HSYNC, both active low. OUT[5:0] is the 6-bit colour.
// One of every four scanlines becomes a framebuffer row. Writes go out
// through a single registered write port that has no back-pressure.
//
// Ports:
//   clock      system clock, rising edge
//   rst_n      asynchronous active-low reset
//   ce         CPU cycle enable; sampling and all state changes need it high
//   out        CPU OUT register
//   fb_addr    write address {row[6:0], col[7:0]}
//   fb_data    colour being written
//   fb_we      write strobe, high for one clock per pixel
//   frame_done one-clock pulse, one clock after the last pixel write of a frame
//   line_err   sticky short-line flag
//
// Optional feature: define GIGATRON_VIDEO_LINECHK_EN to make line_err latch
// high on any short line. Without it, line_err is tied low.

module gigatron_video_capture #(
  parameter int unsigned H_START  = 12,
  parameter int unsigned H_PIXELS = 160,
  parameter int unsigned V_START  = 33,
  parameter int unsigned V_ROWS   = 120
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        ce,
  input  logic [7:0]  out,
  output logic [14:0] fb_addr,
  output logic [5:0]  fb_data,
  output logic        fb_we,
  output logic        frame_done,
  output logic        line_err
);

  localparam logic [5:0] VStartC  = 6'(V_START);
  localparam logic [3:0] HStartM1 = 4'(H_START - 1);
  localparam logic [7:0] ColLast  = 8'(H_PIXELS - 1);
  localparam logic [6:0] RowLast  = 7'(V_ROWS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StVbp,
    StHwait,
    StHporch,
    StActive
  } state_e;

  state_e state_q, state_d;

  // Input sample and the sync bits of the sample before it.
  logic [7:0] s_q;
  logic       vs_prev_q, hs_prev_q;
  logic       vs_rise, vs_fall, hs_rise;

  logic [5:0] line_cnt_q, line_cnt_d;
  logic [1:0] scan_q, scan_d;
  logic [1:0] scan_adv;
  logic [6:0] row_q, row_d;
  logic [7:0] col_q, col_d;
  logic [3:0] hcnt_q, hcnt_d;
  logic       short_line;

  logic       pix_we, last_pix;
  logic [14:0] fb_addr_q;
  logic [5:0]  fb_data_q;
  logic        fb_we_q;
  logic        done_pend_q;
  logic        frame_done_q;

  assign vs_rise = s_q[7] & ~vs_prev_q;
  assign vs_fall = ~s_q[7] & vs_prev_q;
  assign hs_rise = s_q[6] & ~hs_prev_q;

  // The sample register holds inactive sync bits while in reset. This keeps
  // the first real sample after reset from looking like a sync edge.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s_q       <= 8'hC0;
      vs_prev_q <= 1'b1;
      hs_prev_q <= 1'b1;
    end else if (ce) begin
      vs_prev_q <= s_q[7];
      hs_prev_q <= s_q[6];
      s_q       <= out;
    end
  end

  // State register and counters. Every next value equals the current value
  // unless ce is high.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      line_cnt_q <= '0;
      scan_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      hcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      line_cnt_q <= line_cnt_d;
      scan_q     <= scan_d;
      row_q      <= row_d;
      col_q      <= col_d;
      hcnt_q     <= hcnt_d;
    end
  end

  // Next-state logic. Each ce cycle evaluates the sample already held in s_q.
  always_comb begin
    state_d    = state_q;
    line_cnt_d = line_cnt_q;
    scan_d     = scan_q;
    row_d      = row_q;
    col_d      = col_q;
    hcnt_d     = hcnt_q;
    short_line = 1'b0;
    scan_adv   = scan_q + 2'd1;

    if (ce) begin
      if (state_q != StIdle && vs_fall) begin
        // A VSYNC edge overrides any HSYNC edge in the same sample.
        state_d = StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (vs_rise) begin
              line_cnt_d = '0;
              state_d    = StVbp;
            end
          end
          StVbp: begin
            if (hs_rise) begin
              line_cnt_d = line_cnt_q + 6'd1;
              if (line_cnt_q + 6'd1 == VStartC) begin
                scan_d  = '0;
                row_d   = '0;
                state_d = StHwait;
              end
            end
          end
          StHwait: begin
            if (hs_rise) begin
              if (scan_q == 2'd0) begin
                hcnt_d  = '0;
                state_d = StHporch;
              end else begin
                scan_d = scan_adv;
              end
            end
          end
          StHporch: begin
            if (hs_rise) begin
              short_line = 1'b1;
            end else if (hcnt_q == HStartM1) begin
              col_d   = '0;
              state_d = StActive;
            end else begin
              hcnt_d = hcnt_q + 4'd1;
            end
          end
          StActive: begin
            if (hs_rise) begin
              short_line = 1'b1;
            end else if (col_q == ColLast) begin
              if (row_q == RowLast) begin
                state_d = StIdle;
              end else begin
                row_d   = row_q + 7'd1;
                scan_d  = scan_adv;
                state_d = StHwait;
              end
            end else begin
              col_d = col_q + 8'd1;
            end
          end
          default: state_d = StIdle;
        endcase

        // A short line closes the current line as if it had completed. The
        // same HSYNC edge is then evaluated again as HWAIT would evaluate it.
        if (short_line) begin
          row_d = (row_q == RowLast) ? row_q : row_q + 7'd1;
          if (scan_adv == 2'd0) begin
            scan_d  = scan_adv;
            hcnt_d  = '0;
            state_d = StHporch;
          end else begin
            scan_d  = scan_adv + 2'd1;
            state_d = StHwait;
          end
        end
      end
    end
  end

  // Output decode: a pixel is written on a ce cycle in ACTIVE unless the
  // sample carries an abort or a short-line edge.
  always_comb begin
    pix_we   = 1'b0;
    last_pix = 1'b0;
    if (ce && state_q == StActive && !vs_fall && !hs_rise) begin
      pix_we   = 1'b1;
      last_pix = (col_q == ColLast) && (row_q == RowLast);
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      fb_we_q      <= 1'b0;
      done_pend_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      if (pix_we) begin
        fb_addr_q <= {row_q, col_q};
        fb_data_q <= s_q[5:0];
      end
      fb_we_q      <= pix_we;
      done_pend_q  <= last_pix;
      frame_done_q <= done_pend_q;
    end
  end

  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;
  assign fb_we      = fb_we_q;
  assign frame_done = frame_done_q;

`ifdef GIGATRON_VIDEO_LINECHK_EN
  logic line_err_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      line_err_q <= 1'b0;
    end else if (short_line) begin
      line_err_q <= 1'b1;
    end
  end

  assign line_err = line_err_q;
`else
  assign line_err = 1'b0;
`endif

endmodule

// File: tb/tb_gigatron_video_capture.sv
// Scoreboard bench for gigatron_video_capture. The stimulus tasks push the
// expected {addr, data} of each pixel they drive. A negedge monitor pops and
// compares an entry on every fb_we.

module tb_gigatron_video_capture;

  localparam int HStart = 12;
  localparam int HPix   = 160;
  localparam int VStart = 33;

`ifdef GIGATRON_VIDEO_LINECHK_EN
  localparam logic ExpLineErr = 1'b1;
`else
  localparam logic ExpLineErr = 1'b0;
`endif

  typedef struct packed {
    logic [14:0] addr;
    logic [5:0]  data;
  } wr_t;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic [7:0]  out = 8'hC0;
  logic [14:0] fb_addr;
  logic [5:0]  fb_data;
  logic        fb_we;
  logic        frame_done;
  logic        line_err;

  gigatron_video_capture dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .ce         (ce),
    .out        (out),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_we      (fb_we),
    .frame_done (frame_done),
    .line_err   (line_err)
  );

  always #5 clock = ~clock;

  wr_t         exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_writes = 0;
  int          n_done = 0;
  bit          tog = 1'b0;
  logic        prev_we = 1'b0;
  logic [14:0] prev_addr = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endfunction

  // Monitor: samples the outputs at the negedge, away from the active edge.
  always @(negedge clock) begin
    wr_t e;
    if (fb_we) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", fb_addr, fb_data);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", 32'(fb_addr), 32'(e.addr));
        chk("write_data", 32'(fb_data), 32'(e.data));
      end
    end
    if (frame_done) begin
      n_done++;
      // The last pixel of row 119 must have been written on the clock before.
      chk("frame_done_timing", 32'({prev_we, prev_addr}), 32'({1'b1, 15'h779F}));
    end
    prev_we   = fb_we;
    prev_addr = fb_addr;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input logic [7:0] v, input logic c);
    out = v;
    ce  = c;
    @(posedge clock);
    #1;
  endtask

  // One CE cycle. In toggle mode every CE-high cycle is followed by a CE-low
  // cycle that presents junk (both syncs low), which the DUT must not sample.
  task automatic smp(input logic [7:0] v);
    cyc(v, 1'b1);
    if (tog) cyc(8'h00, 1'b0);
  endtask

  task automatic skip_line();
    cyc(8'h80, 1'b1);
    cyc(8'hC0, 1'b1);
  endtask

  task automatic start_frame();
    cyc(8'h40, 1'b1);
    cyc(8'h40, 1'b1);
    cyc(8'hC0, 1'b1);
    repeat (VStart) skip_line();
  endtask

  // Reset one clock mid-ACTIVE, right after the pixel sample for the current
  // column. That sample is still in the pipeline and must be dropped.
  task automatic do_reset();
    wr_t w;
    @(negedge clock);
    #1;
    chk("pending_before_reset", 32'(exp_q.size()), 32'd1);
    chk("we_before_reset", 32'(fb_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_fb_we", 32'(fb_we), 32'd0);
    chk("reset_fb_addr", 32'(fb_addr), 32'd0);
    chk("reset_line_err", 32'(line_err), 32'd0);
    w = exp_q.pop_back();
    @(negedge clock);
    #1;
    rst_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic cap_line(input int row, input int abort_col, input int short_col,
                          input int reset_col);
    wr_t        w;
    logic [7:0] v;
    smp(8'h80);
    smp(8'hC0);
    repeat (HStart) smp(8'hEA);
    for (int c = 0; c < HPix; c++) begin
      if (c == abort_col) begin
        smp(8'h40);
        return;
      end
      if (c == short_col) begin
        smp(8'hC0);
        return;
      end
      w.addr = {7'(row), 8'(c)};
      w.data = 6'(c);
      exp_q.push_back(w);
      // HSYNC goes low on the pixel before an injected short-line edge.
      v = {1'b1, (c != short_col - 1), 6'(c)};
      smp(v);
      if (c == reset_col) begin
        do_reset();
        return;
      end
    end
  endtask

  task automatic run_frame(input int last_row, input int abort_row, input int abort_col,
                           input int short_row, input int short_col, input int tog_row,
                           input int reset_row, input int reset_col);
    start_frame();
    for (int r = 0; r <= last_row; r++) begin
      tog = (r == tog_row);
      cap_line(r, (r == abort_row) ? abort_col : -1, (r == short_row) ? short_col : -1,
               (r == reset_row) ? reset_col : -1);
      tog = 1'b0;
      if (r == abort_row || r == reset_row) return;
      // The short-line edge has already used up one of the three skipped lines.
      if (r != last_row) repeat ((r == short_row) ? 2 : 3) skip_line();
    end
  endtask

  task automatic idle_vs_low();
    repeat (3) begin
      cyc(8'h00, 1'b1);
      cyc(8'h40, 1'b1);
    end
    repeat (200) cyc(8'h40, 1'b1);
  endtask

  initial begin
    int w0;

    // Reset held with ce high and syncs inactive.
    rst_n = 1'b0;
    ce    = 1'b1;
    out   = 8'hC0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_fb_we", 32'(fb_we), 32'd0);
    chk("rst_fb_addr", 32'(fb_addr), 32'd0);
    chk("rst_fb_data", 32'(fb_data), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_line_err", 32'(line_err), 32'd0);
    rst_n = 1'b1;
    repeat (20) cyc(8'hC0, 1'b1);
    chk("post_rst_writes", 32'(n_writes), 32'd0);
    chk("post_rst_fb_we", 32'(fb_we), 32'd0);

    // Frame 1: full standard frame.
    w0 = n_writes;
    run_frame(119, -1, -1, -1, -1, -1, -1, -1);
    repeat (8) cyc(8'hC0, 1'b1);
    chk("f1_writes", 32'(n_writes - w0), 32'd19200);
    chk("f1_done", 32'(n_done), 32'd1);
    chk("f1_queue", 32'(exp_q.size()), 32'd0);
    chk("f1_line_err", 32'(line_err), 32'd0);

    // Frame 2: ce toggling on row 2, short line on row 5 at col 100,
    // VSYNC abort on row 60 at col 50.
    w0 = n_writes;
    run_frame(119, 60, 50, 5, 100, 2, -1, -1);
    idle_vs_low();
    chk("f2_writes", 32'(n_writes - w0), 32'd9590);
    chk("f2_done", 32'(n_done), 32'd1);
    chk("f2_queue", 32'(exp_q.size()), 32'd0);
    chk("f2_line_err", 32'(line_err), 32'(ExpLineErr));

    // Frame 3: reset pulse on row 3 after the col 80 sample.
    w0 = n_writes;
    run_frame(119, -1, -1, -1, -1, -1, 3, 80);
    repeat (4) begin
      skip_line();
      repeat (180) cyc(8'hD5, 1'b1);
    end
    chk("f3_writes", 32'(n_writes - w0), 32'd560);
    chk("f3_queue", 32'(exp_q.size()), 32'd0);
    chk("f3_line_err", 32'(line_err), 32'd0);

    // Frame 4: capture restarts at row 0 after a fresh VSYNC.
    w0 = n_writes;
    run_frame(119, 1, 159, -1, -1, -1, -1, -1);
    idle_vs_low();
    chk("f4_writes", 32'(n_writes - w0), 32'd319);
    chk("f4_done", 32'(n_done), 32'd1);
    chk("f4_queue", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
